// File: rtl/bus_dest_regs.sv
`default_nettype none
// ============================================================================
// Module      : bus_dest_regs
// Description : Bus destination register file with load masks, pointer
//               increments, AC zero flag and a delayed data-memory write port.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_dest_regs #(
  parameter int REG_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [REG_WIDTH-1:0] busIn,
  input  logic [7:0]           wrEn,
  input  logic [3:0]           incEn,
  input  logic                 dmWrReq,
  output logic [REG_WIDTH-1:0] AR,
  output logic [REG_WIDTH-1:0] R,
  output logic [REG_WIDTH-1:0] RL,
  output logic [REG_WIDTH-1:0] RC,
  output logic [REG_WIDTH-1:0] RP,
  output logic [REG_WIDTH-1:0] RQ,
  output logic [REG_WIDTH-1:0] R1,
  output logic [REG_WIDTH-1:0] AC,
  output logic                 zFlag,
  output logic                 dmWrEn,
  output logic [REG_WIDTH-1:0] dmAddr,
  output logic [REG_WIDTH-1:0] dmData
);

  localparam int                   c_numRegs = 8;
  localparam logic [REG_WIDTH-1:0] c_one     = {{(REG_WIDTH-1){1'b0}}, 1'b1};

  logic [REG_WIDTH-1:0] r_regs [c_numRegs];
  logic [REG_WIDTH-1:0] w_next [c_numRegs];
  logic                 r_zFlag;
  logic                 r_dmWrEn;
  logic [REG_WIDTH-1:0] r_dmAddr;
  logic [REG_WIDTH-1:0] r_dmData;

  // Register index order: AR, R, RL, RC, RP, RQ, R1, AC. Indices 2..5 map to incEn[0..3].
  for (genvar i = 0; i < c_numRegs; i++) begin : g_next
    if (i >= 2 && i <= 5) begin : g_incReg
      assign w_next[i] = wrEn[i]     ? busIn :
                         incEn[i-2]  ? r_regs[i] + c_one :
                                       r_regs[i];
    end else begin : g_loadReg
      assign w_next[i] = wrEn[i] ? busIn : r_regs[i];
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < c_numRegs; i++) begin
        r_regs[i] <= '0;
      end
      r_zFlag  <= 1'b1;
      r_dmWrEn <= 1'b0;
      r_dmAddr <= '0;
      r_dmData <= '0;
    end else begin
      for (int i = 0; i < c_numRegs; i++) begin
        r_regs[i] <= w_next[i];
      end
      r_zFlag  <= (w_next[7] == '0);
      r_dmWrEn <= dmWrReq;
      // Address uses AR before this edge, so a concurrent AR load cannot redirect the write.
      if (dmWrReq) begin
        r_dmAddr <= r_regs[0];
        r_dmData <= busIn;
      end
    end
  end

  assign AR     = r_regs[0];
  assign R      = r_regs[1];
  assign RL     = r_regs[2];
  assign RC     = r_regs[3];
  assign RP     = r_regs[4];
  assign RQ     = r_regs[5];
  assign R1     = r_regs[6];
  assign AC     = r_regs[7];
  assign zFlag  = r_zFlag;
  assign dmWrEn = r_dmWrEn;
  assign dmAddr = r_dmAddr;
  assign dmData = r_dmData;

endmodule
`default_nettype wire
